// File: rtl/uart_cfg_pkg.sv
// Shared constants and types for the UART 16550 CSR configuration sequencer.
package uart_cfg_pkg;

  localparam int RBR_THR_DLL = 0;
  localparam int IER_DLM     = 1;
  localparam int IIR_FCR     = 2;
  localparam int LCR         = 3;

  localparam int LCR_DLAB_BIT = 7;
  localparam int STEP_COUNT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP,
    ST_FIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_LCR     = 2'd2,
    ERR_IER     = 2'd3
  } err_code_t;

  // Full LCR byte: software supplies the frame format, the sequencer owns DLAB.
  function automatic logic [7:0] lcr_value(input logic [6:0] frame, input logic dlab);
    logic [7:0] v;
    v = {1'b0, frame};
    v[LCR_DLAB_BIT] = dlab;
    return v;
  endfunction

endpackage

// File: rtl/uart_cfg_step_rom.sv
// Step index to Wishbone transaction decode for the configuration sequence.
module uart_cfg_step_rom
  import uart_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic [2:0]            step,
  input  logic [15:0]           divisor,
  input  logic [6:0]            lcr_frame,
  input  logic [7:0]            fcr,
  input  logic [3:0]            ier,
  output logic [ADDR_WIDTH-1:0] adr,
  output logic                  we,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] exp_data,
  output logic [DATA_WIDTH-1:0] mask
);

  // Reads carry zero write data; only the IER readback ignores the upper nibble.
  always_comb begin
    adr      = '0;
    we       = 1'b0;
    data     = '0;
    exp_data = '0;
    mask     = '0;
    case (step)
      3'd0: begin
        adr  = ADDR_WIDTH'(LCR);
        we   = 1'b1;
        data = DATA_WIDTH'(lcr_value(lcr_frame, 1'b1));
      end
      3'd1: begin
        adr  = ADDR_WIDTH'(RBR_THR_DLL);
        we   = 1'b1;
        data = DATA_WIDTH'(divisor[7:0]);
      end
      3'd2: begin
        adr  = ADDR_WIDTH'(IER_DLM);
        we   = 1'b1;
        data = DATA_WIDTH'(divisor[15:8]);
      end
      3'd3: begin
        adr  = ADDR_WIDTH'(LCR);
        we   = 1'b1;
        data = DATA_WIDTH'(lcr_value(lcr_frame, 1'b0));
      end
      3'd4: begin
        adr  = ADDR_WIDTH'(IIR_FCR);
        we   = 1'b1;
        data = DATA_WIDTH'(fcr);
      end
      3'd5: begin
        adr  = ADDR_WIDTH'(IER_DLM);
        we   = 1'b1;
        data = DATA_WIDTH'({4'b0000, ier});
      end
      3'd6: begin
        adr      = ADDR_WIDTH'(LCR);
        exp_data = DATA_WIDTH'(lcr_value(lcr_frame, 1'b0));
        mask     = DATA_WIDTH'(8'hFF);
      end
      3'd7: begin
        adr      = ADDR_WIDTH'(IER_DLM);
        exp_data = DATA_WIDTH'({4'b0000, ier});
        mask     = DATA_WIDTH'(8'h0F);
      end
    endcase
  end

endmodule

// File: rtl/uart_cfg_sequencer.sv
// Wishbone classic master that programs the UART 16550 CSRs and verifies LCR/IER by readback.
module uart_cfg_sequencer
  import uart_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [15:0]           divisor,
  input  logic [6:0]            lcr_frame,
  input  logic [7:0]            fcr,
  input  logic [3:0]            ier,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [2:0]            err_step,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  output logic [3:0]            wbm_sel_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                  wbm_ack_i
);

  localparam logic [2:0] LAST_STEP     = 3'(STEP_COUNT - 1);
  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

  state_t                state;
  logic [2:0]            step;
  logic [2:0]            rom_step;
  logic [7:0]            tcnt;
  logic [8:0]            tcnt_inc;
  logic [15:0]           div_q;
  logic [6:0]            lcr_q;
  logic [7:0]            fcr_q;
  logic [3:0]            ier_q;
  logic [ADDR_WIDTH-1:0] rom_adr;
  logic                  rom_we;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] rom_exp;
  logic [DATA_WIDTH-1:0] rom_mask;
  logic                  read_bad;

  // In GAP the bus registers are loaded for the following step.
  assign rom_step = (state == ST_GAP) ? step + 3'd1 : step;
  assign tcnt_inc = {1'b0, tcnt} + 9'd1;
  assign read_bad = !rom_we && (((wbm_dat_i ^ rom_exp) & rom_mask) != '0);

  uart_cfg_step_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rom (
    .step      (rom_step),
    .divisor   (div_q),
    .lcr_frame (lcr_q),
    .fcr       (fcr_q),
    .ier       (ier_q),
    .adr       (rom_adr),
    .we        (rom_we),
    .data      (rom_data),
    .exp_data  (rom_exp),
    .mask      (rom_mask)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= ST_IDLE;
      step      <= '0;
      tcnt      <= '0;
      div_q     <= '0;
      lcr_q     <= '0;
      fcr_q     <= '0;
      ier_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      err_step  <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            div_q    <= divisor;
            lcr_q    <= lcr_frame;
            fcr_q    <= fcr;
            ier_q    <= ier;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            err_step <= '0;
            busy     <= 1'b1;
            step     <= '0;
            tcnt     <= '0;
            state    <= ST_ISSUE;
          end
        end

        // The first ISSUE cycle after start only loads the bus from the fresh snapshot.
        ST_ISSUE: begin
          if (!wbm_cyc_o) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= rom_we;
            wbm_adr_o <= rom_adr;
            wbm_dat_o <= rom_data;
            wbm_sel_o <= 4'hF;
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            if (read_bad) begin
              err      <= 1'b1;
              err_code <= (step == 3'd6) ? ERR_LCR : ERR_IER;
              err_step <= step;
              state    <= ST_FIN;
            end else if (step == LAST_STEP) begin
              state <= ST_FIN;
            end else begin
              state <= ST_GAP;
            end
          end else if (tcnt_inc == TIMEOUT_LIMIT) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            err       <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            err_step  <= step;
            state     <= ST_FIN;
          end else begin
            tcnt <= tcnt_inc[7:0];
          end
        end

        ST_GAP: begin
          step      <= step + 3'd1;
          tcnt      <= '0;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_we_o  <= rom_we;
          wbm_adr_o <= rom_adr;
          wbm_dat_o <= rom_data;
          wbm_sel_o <= 4'hF;
          state     <= ST_ISSUE;
        end

        ST_FIN: begin
          busy  <= 1'b0;
          done  <= !err;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_cfg_sequencer.md
Name: uart_cfg_sequencer

Overview:
Wishbone classic master that programs the UART 16550 CSR block after reset or on software request. On start it snapshots the configuration inputs and issues a fixed write sequence: DLAB set, DLL, DLM, line format, FCR, IER. It then reads back LCR and IER and checks them. It sits in front of the uart_top Wishbone slave port, which the CSR formal checker already observes, and reports done, error code and failing step.

Parameters:
ADDR_WIDTH, 5, Wishbone address width (matches UART_ADDR_WIDTH)
DATA_WIDTH, 8, Wishbone data width (8-bit UART bus mode)
TIMEOUT_CYCLES, 255, max cycles waiting for ack before abort (1..255, 8-bit counter)

Ports:
clk  input  1  single clock
rstN  input  1  asynchronous active-low reset
start  input  1  single-cycle request; honoured only in IDLE
divisor  input  16  baud divisor {DLM,DLL}
lcr_frame  input  7  LCR[6:0] line format; DLAB is controlled internally
fcr  input  8  FIFO control value
ier  input  4  interrupt enable value
busy  output  1  sequence in progress
done  output  1  sticky: sequence completed with no error; cleared by next accepted start
err  output  1  sticky error; cleared by next accepted start
err_code  output  2  0 none, 1 ack timeout, 2 LCR mismatch, 3 IER mismatch
err_step  output  3  step index at which the error occurred
wbm_cyc_o  output  1  bus cycle
wbm_stb_o  output  1  strobe
wbm_we_o  output  1  write enable
wbm_adr_o  output  ADDR_WIDTH  register address
wbm_dat_o  output  DATA_WIDTH  write data
wbm_sel_o  output  4  byte select: 4'hF during a transaction, 0 otherwise
wbm_dat_i  input  DATA_WIDTH  read data
wbm_ack_i  input  1  slave acknowledge

Behaviour:
- Reset (async, rstN low): all outputs 0, FSM to IDLE, step=0, snapshot registers 0. Takes effect immediately, including mid-transaction; the bus drops with no completion.
- All outputs are registered.
- Step table (addr / we / data):
  - 0: 3 / W / {1, lcr_frame}
  - 1: 0 / W / divisor[7:0]
  - 2: 1 / W / divisor[15:8]
  - 3: 3 / W / {0, lcr_frame}
  - 4: 2 / W / fcr
  - 5: 1 / W / {4'b0, ier}
  - 6: 3 / R, expect {0, lcr_frame}
  - 7: 1 / R, expect {4'b0, ier}, compare bits [3:0] only
- FSM states: IDLE, ISSUE, GAP, FIN.
- IDLE: start=1 snapshots inputs, clears done/err/err_code/err_step, sets busy, step=0, goes to ISSUE. Buses are asserted on the next cycle.
- ISSUE: cyc=stb=1, sel=F, adr/we/dat driven from the table for the current step; dat_o=0 for reads. The timeout counter increments every cycle in this state.
  - ack=1: latch and compare read data on this cycle. Next cycle cyc/stb/we/sel=0 and the state is GAP, or FIN if step=7 or a mismatch occurred.
  - Counter reaches TIMEOUT_CYCLES without ack: err=1, code 1, err_step=step, drop bus, go to FIN.
- Mismatch on step 6 sets code 2; on step 7 sets code 3. err_step records the step. The sequence aborts.
- GAP: exactly one idle bus cycle. step increments, timeout counter clears, return to ISSUE.
- FIN: busy=0; done=1 if no error. Return to IDLE next cycle.
- Latency with a zero-wait slave (ack one cycle after stb): 3 cycles per step (ISSUE, ack, GAP). Start to busy falling is 24 cycles plus 1 for FIN. Each extra wait state adds 1 cycle.
- start during busy is ignored; the snapshot is not updated.
- ack outside ISSUE is ignored.
- If ack arrives on the same cycle the counter hits the limit, ack wins.
- Simultaneous start and reset: reset wins.
- Input changes after start have no effect until the next accepted start.

Decomposition:
- Package uart_cfg_pkg holds:
  - UART register address constants: RBR_THR_DLL=0, IER_DLM=1, IIR_FCR=2, LCR=3.
  - LCR_DLAB_BIT=7.
  - State enum.
  - err_code enum.
  - Step count constant 8.
- One natural sub-module: uart_cfg_step_rom, a combinational step to {adr, we, data, expect, mask} decode from the snapshot. The FSM, timeout counter and Wishbone driver stay in the top.

Test Plan:
- Nominal: divisor=16'h0145, lcr_frame=7'h03, fcr=8'hC7, ier=4'h5, zero-wait slave model → writes (3,83),(0,45),(1,01),(3,03),(2,C7),(1,05), then reads of 3 and 1 return 03/05. done=1, err=0, busy high 25 cycles.
- Wait states: slave acks 3 cycles after stb → same bus sequence, one idle cycle between transactions, total busy = 8×5+1 = 41 cycles, done=1.
- Timeout: TIMEOUT_CYCLES=8, slave never acks step 2 → bus drops after 8 ISSUE cycles. err=1, err_code=1, err_step=2, done=0, no further transactions.
- Readback mismatch: slave returns 8'h83 on LCR read → err_code=2, err_step=6, step 7 never issued. A separate run returning IER 8'hF5 (upper nibble ignored) passes; IER 8'h04 gives err_code=3, err_step=7.
- start while busy: second start at step 3 with divisor=16'hFFFF → ignored, DLL/DLM remain 45/01, single done.
- Reset mid-op: rstN low during step 4 ISSUE → cyc/stb drop in the same cycle, busy/done/err=0. A later start replays from step 0.
